// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 stream multiplexer: mode encodings and width helpers.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Channel index width; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_n_1_stream_if.sv
// Multi-channel input streams plus the single tagged output stream of the multiplexer.
interface mux_n_1_stream_if
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned SEL_W = sel_w(NUM_CH);

    logic [NUM_CH-1:0]        in_valid_in;
    logic [NUM_CH*DATA_W-1:0] in_data_in;
    logic [NUM_CH-1:0]        in_ready_out;
    logic                     out_valid_out;
    logic [DATA_W-1:0]        out_data_out;
    logic [SEL_W-1:0]         out_ch_out;
    logic                     out_ready_in;

    // Producers and consumer side.
    modport master (
        output in_valid_in, in_data_in, out_ready_in,
        input  in_ready_out, out_valid_out, out_data_out, out_ch_out
    );

    // Multiplexer side.
    modport slave (
        input  in_valid_in, in_data_in, out_ready_in,
        output in_ready_out, out_valid_out, out_data_out, out_ch_out
    );

endinterface

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: grants the first requester after the last accepted channel.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned SEL_W  = sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    input  logic [SEL_W-1:0]  adv_idx,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] idx;
    logic             found;

    // Scan ptr+1, ptr+2, ... modulo NUM_CH for the first request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int off = 1; off <= int'(NUM_CH); off++) begin
            idx = SEL_W'((32'(ptr_q) + 32'(off)) % NUM_CH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Reset to the last channel so channel 0 has top priority first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SEL_W'(NUM_CH - 1);
        end else if (advance) begin
            ptr_q <= adv_idx;
        end
    end

endmodule

// File: rtl/mux_n_1_stream.sv
// N:1 registered stream multiplexer with external-select or round-robin channel choice.
module mux_n_1_stream
    import mux_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned SEL_W  = sel_w(NUM_CH)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  mode_in,
    input  logic [SEL_W-1:0]      sel_in,
    mux_n_1_stream_if.slave       bus,
    output logic                  sel_err_out,
    output logic [CNT_W-1:0]      beat_cnt_out
);

    logic [NUM_CH-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_CH-1:0] sel_grant;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [NUM_CH-1:0] ready;
    logic [DATA_W-1:0] grant_data;
    logic              sel_in_range;
    logic              load;
    logic              xfer;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic [CNT_W-1:0]  cnt_q;

    rr_arbiter_n #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .req       (bus.in_valid_in),
        .advance   (xfer),
        .adv_idx   (grant_idx),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // External select decode; only the selected channel's valid matters.
    always_comb begin
        sel_in_range = (32'(sel_in) < NUM_CH);
        sel_err_out  = (mode_in == MODE_SEL) && !sel_in_range;
        sel_grant    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            sel_grant[i] = (mode_in == MODE_SEL) && (32'(sel_in) == 32'(i)) && bus.in_valid_in[i];
        end
    end

    // Grant selection, ready generation and data mux.
    always_comb begin
        grant      = (mode_in == MODE_RR) ? rr_grant : sel_grant;
        grant_idx  = (mode_in == MODE_RR) ? rr_idx : sel_in;
        load       = !out_valid_q || bus.out_ready_in;
        ready      = (rst_n_in && load) ? grant : '0;
        xfer       = |ready;
        grant_data = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (grant[i]) begin
                grant_data = bus.in_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output register and accepted-beat counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= xfer || (out_valid_q && !bus.out_ready_in);
            if (xfer) begin
                out_data_q <= grant_data;
                out_ch_q   <= grant_idx;
                cnt_q      <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready_out  = ready;
    assign bus.out_valid_out = out_valid_q;
    assign bus.out_data_out  = out_data_q;
    assign bus.out_ch_out    = out_ch_q;
    assign beat_cnt_out      = cnt_q;

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Scoreboard bench for mux_n_1_stream: 5 channels so out-of-range selects are representable, 4-bit counter to hit wrap.
module tb_mux_n_1_stream;
    import mux_pkg::*;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SEL_W  = sel_w(NUM_CH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  ch;
        logic [CNT_W-1:0]  cnt;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode = MODE_RR;
    logic [SEL_W-1:0] sel = '0;
    logic             sel_err;
    logic [CNT_W-1:0] beat_cnt;

    mux_n_1_stream_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    mux_n_1_stream #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .mode_in      (mode),
        .sel_in       (sel),
        .bus          (bus),
        .sel_err_out  (sel_err),
        .beat_cnt_out (beat_cnt)
    );

    always #5 clk = ~clk;

    beat_t             sb[$];
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [SEL_W-1:0]  m_ch;
    logic [CNT_W-1:0]  m_cnt;
    logic [SEL_W-1:0]  m_ptr;
    int                n_pass = 0;
    int                n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = '0;
        m_cnt   = '0;
        m_ptr   = SEL_W'(NUM_CH - 1);
        sb.delete();
    endtask

    task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
        bus.in_data_in[ch*DATA_W +: DATA_W] = v;
    endtask

    // One clock: predict grant at mid-cycle, push expected beat, compare after the edge.
    task automatic step();
        logic [NUM_CH-1:0] g;
        logic [SEL_W-1:0]  gi;
        logic [SEL_W-1:0]  idx;
        logic              xfer;
        beat_t             b;
        @(negedge clk);
        g  = '0;
        gi = '0;
        b  = '0;
        if (mode == MODE_SEL) begin
            if (32'(sel) < NUM_CH && bus.in_valid_in[sel]) begin
                g[sel] = 1'b1;
                gi     = sel;
            end
        end else begin
            for (int off = 1; off <= int'(NUM_CH); off++) begin
                idx = SEL_W'((32'(m_ptr) + 32'(off)) % NUM_CH);
                if (g == '0 && bus.in_valid_in[idx]) begin
                    g[idx] = 1'b1;
                    gi     = idx;
                end
            end
        end
        if (m_valid && !bus.out_ready_in) g = '0;
        xfer = |g;
        check("in_ready", 32'(bus.in_ready_out), 32'(g));
        check("sel_err", 32'(sel_err), 32'(mode == MODE_SEL && 32'(sel) >= NUM_CH));
        if (xfer) begin
            b.data = bus.in_data_in[32'(gi)*DATA_W +: DATA_W];
            b.ch   = gi;
            b.cnt  = m_cnt + CNT_W'(1);
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            b       = sb.pop_front();
            m_ptr   = b.ch;
            m_cnt   = b.cnt;
            m_data  = b.data;
            m_ch    = b.ch;
            m_valid = 1'b1;
        end else if (bus.out_ready_in) begin
            m_valid = 1'b0;
        end
        check("out_valid", 32'(bus.out_valid_out), 32'(m_valid));
        check("out_data", 32'(bus.out_data_out), 32'(m_data));
        check("out_ch", 32'(bus.out_ch_out), 32'(m_ch));
        check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        bus.in_valid_in  = '1;
        bus.out_ready_in = 1'b1;
        for (int i = 0; i < int'(NUM_CH); i++) set_data(i, DATA_W'(8'h10 + i));

        // Reset holds all ready low even with every channel valid.
        #12;
        check("rst_ready", 32'(bus.in_ready_out), 32'(0));
        check("rst_valid", 32'(bus.out_valid_out), 32'(0));
        check("rst_cnt", 32'(beat_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin over all channels, one beat per cycle, starting at ch0.
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_seq", 32'(bus.out_ch_out), 32'(i % int'(NUM_CH)));
        end

        // Backpressure: held beat stays, no grants, pointer frozen.
        bus.out_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", 32'(bus.out_data_out), 32'(8'h12));
        end
        bus.out_ready_in = 1'b1;
        step();
        check("resume_ch", 32'(bus.out_ch_out), 32'(3));
        for (int i = 0; i < 8; i++) step();
        check("cnt_wrap", 32'(beat_cnt), 32'(1));

        // External select of ch2 with every channel valid.
        mode = MODE_SEL;
        sel  = SEL_W'(2);
        set_data(2, 8'hA5);
        step();
        check("sel_data", 32'(bus.out_data_out), 32'(8'hA5));
        check("sel_ch", 32'(bus.out_ch_out), 32'(2));

        // Out-of-range select: error flag, no transfer.
        sel = SEL_W'(5);
        step();
        check("oor_err", 32'(sel_err), 32'(1));
        check("oor_cnt", 32'(beat_cnt), 32'(2));

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            mode             = logic'($urandom_range(0, 1));
            sel              = SEL_W'($urandom_range(0, 7));
            bus.in_valid_in  = NUM_CH'($urandom);
            bus.out_ready_in = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < int'(NUM_CH); i++) set_data(i, DATA_W'($urandom));
            step();
        end

        // Asynchronous reset mid-stream discards the held beat at once.
        mode             = MODE_RR;
        bus.in_valid_in  = '1;
        bus.out_ready_in = 1'b1;
        step();
        step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid_out), 32'(0));
        check("mid_rst_ready", 32'(bus.in_ready_out), 32'(0));
        check("mid_rst_cnt", 32'(beat_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_seq", 32'(bus.out_ch_out), 32'(i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
